// File: rtl/l1_data_cache_hitrate_ctrl.sv
// L1 data-cache hit-rate monitor: every 100 accesses it samples the hit counter,
// classifies the hit rate into LOW/MID/HIGH with hysteresis, and exposes a status read port.
module l1_data_cache_hitrate_ctrl #(
    parameter int P_SETTLE = 4,
    parameter int P_HYST   = 5
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iENABLE,
    input  logic        iCACHE_VALID,
    input  logic [6:0]  iINFO_COUNT,
    input  logic [6:0]  iTHRESH_LOW,
    input  logic [6:0]  iTHRESH_HIGH,
    input  logic        iRD_REQ,
    output logic        oRD_ACK,
    output logic [24:0] oRD_DATA,
    output logic        oSAMPLE_VALID,
    output logic [6:0]  oSAMPLE_COUNT,
    output logic [1:0]  oLEVEL,
    output logic        oLEVEL_CHANGE,
    output logic [15:0] oWINDOW_CNT,
    output logic        oCFG_ERR
);

    typedef enum logic [1:0] {IDLE, FILL, SETTLE, SAMPLE} state_t;

    localparam logic [1:0] LVL_LOW  = 2'b00;
    localparam logic [1:0] LVL_MID  = 2'b01;
    localparam logic [1:0] LVL_HIGH = 2'b10;
    localparam logic [3:0] SETTLE_LAST = 4'(P_SETTLE - 1);
    localparam logic [7:0] HYST8 = 8'(P_HYST);

    state_t      state;
    logic [6:0]  acc_cnt;
    logic [3:0]  timer;
    logic [6:0]  acc_inc;
    logic [6:0]  smp_clamped;
    logic [1:0]  level_eval;
    logic [15:0] window_nxt;
    logic        cfg_bad;
    logic        do_sample;
    logic        next_is_sample;

    function automatic logic [6:0] clamp_sample(input logic [6:0] v);
        return (v > 7'd100) ? 7'd100 : v;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Exit thresholds are formed 8 bits wide so neither sum nor difference wraps.
    function automatic logic [7:0] low_exit(input logic [6:0] lo);
        logic [7:0] s;
        s = {1'b0, lo} + HYST8;
        return (s > 8'd100) ? 8'd100 : s;
    endfunction

    function automatic logic [7:0] high_exit(input logic [6:0] hi);
        return ({1'b0, hi} > HYST8) ? ({1'b0, hi} - HYST8) : 8'd0;
    endfunction

    assign acc_inc        = acc_cnt + 7'(iCACHE_VALID);
    assign smp_clamped    = clamp_sample(iINFO_COUNT);
    assign cfg_bad        = (iTHRESH_LOW > iTHRESH_HIGH);
    assign window_nxt     = sat_inc16(oWINDOW_CNT);
    assign do_sample      = iENABLE && (state == SAMPLE);
    assign next_is_sample = iENABLE && (state == SETTLE) && (timer == SETTLE_LAST);

    always_comb begin
        level_eval = oLEVEL;
        if (!cfg_bad) begin
            if (smp_clamped > iTHRESH_HIGH)
                level_eval = LVL_HIGH;
            else if (smp_clamped < iTHRESH_LOW)
                level_eval = LVL_LOW;
            else if ((oLEVEL == LVL_LOW) && ({1'b0, smp_clamped} >= low_exit(iTHRESH_LOW)))
                level_eval = LVL_MID;
            else if ((oLEVEL == LVL_HIGH) && ({1'b0, smp_clamped} <= high_exit(iTHRESH_HIGH)))
                level_eval = LVL_MID;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state         <= IDLE;
            acc_cnt       <= 7'd0;
            timer         <= 4'd0;
            oLEVEL        <= LVL_MID;
            oSAMPLE_COUNT <= 7'd0;
            oWINDOW_CNT   <= 16'd0;
            oSAMPLE_VALID <= 1'b0;
            oLEVEL_CHANGE <= 1'b0;
            oCFG_ERR      <= 1'b0;
            oRD_ACK       <= 1'b0;
            oRD_DATA      <= 25'd0;
        end else begin
            oSAMPLE_VALID <= 1'b0;
            oLEVEL_CHANGE <= 1'b0;
            oRD_ACK       <= 1'b0;
            if (!iENABLE) begin
                state    <= IDLE;
                acc_cnt  <= 7'd0;
                timer    <= 4'd0;
                oCFG_ERR <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= FILL;
                        acc_cnt <= 7'd0;
                        timer   <= 4'd0;
                    end
                    FILL: begin
                        if (iCACHE_VALID) begin
                            if (acc_cnt == 7'd99) begin
                                acc_cnt <= 7'd0;
                                timer   <= 4'd0;
                                state   <= SETTLE;
                            end else begin
                                acc_cnt <= acc_cnt + 7'd1;
                            end
                        end
                    end
                    SETTLE: begin
                        acc_cnt <= acc_inc;
                        if (timer == SETTLE_LAST)
                            state <= SAMPLE;
                        else
                            timer <= timer + 4'd1;
                    end
                    SAMPLE: begin
                        // Accesses seen while settling/sampling belong to the next window.
                        acc_cnt       <= acc_inc;
                        timer         <= 4'd0;
                        state         <= FILL;
                        oSAMPLE_COUNT <= smp_clamped;
                        oSAMPLE_VALID <= 1'b1;
                        oWINDOW_CNT   <= window_nxt;
                        oLEVEL        <= level_eval;
                        oLEVEL_CHANGE <= (level_eval != oLEVEL);
                        if (cfg_bad)
                            oCFG_ERR <= 1'b1;
                    end
                endcase
            end
            // An ack that would land in SAMPLE waits one cycle so it reports the new sample.
            if (iRD_REQ && !oRD_ACK && !next_is_sample) begin
                oRD_ACK  <= 1'b1;
                oRD_DATA <= do_sample ? {level_eval, smp_clamped, window_nxt}
                                      : {oLEVEL, oSAMPLE_COUNT, oWINDOW_CNT};
            end
        end
    end

endmodule
